// File: rtl/alu_arbiter.sv
// Shared-ALU arbiter: round-robin access for NREQ requesters to one valid/ready ALU.
// Latency: accept at T, alu_valid at T+1, result at T+2 (nominal ALU), resp_valid at T+3.
// Backpressure: one op in flight; no new accept until the owner takes its result via resp_ready.

package cpu_types_pkg;

    // ALU operation select shared by requesters and the ALU itself.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alusel_e;

endpackage

// Round-robin owner of the single ALU; sequences the one-pulse start and returns results.
// Latency: 4 cycles accept-to-accept minimum; resp_valid three cycles after accept.
// Backpressure: RESP holds until the owning requester raises resp_ready; IDLE is the only accept point.
module alu_arbiter
    import cpu_types_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    input  alusel_e                 req_sel [NREQ],
    output logic [NREQ-1:0]         resp_valid,
    input  logic [NREQ-1:0]         resp_ready,
    output logic [WIDTH-1:0]        resp_data,
    output logic                    alu_valid,
    input  logic                    alu_ready,
    output logic [WIDTH-1:0]        alu_a,
    output logic [WIDTH-1:0]        alu_b,
    output alusel_e                 alu_sel,
    input  logic [WIDTH-1:0]        alu_result,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    output logic                    err
);

    localparam int IDW = $clog2(NREQ);
    localparam int WDW = $clog2(TIMEOUT + 1);

    // Returned in place of a result when the ALU never answers.
    localparam logic [WIDTH-1:0] HANG_DATA = WIDTH'(32'hDEADBEEF);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   gnt_idx;
    logic [IDW-1:0]   scan_idx;
    logic             gnt_found;
    logic             accept;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    alusel_e          sel_op;
    logic [WDW-1:0]   wd_cnt;
    logic             wd_fire;
    logic             alu_done;
    logic             resp_done;

    // Round-robin scan starting one past the last owner; first valid requester wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = rr_ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (scan_idx == IDW'(NREQ - 1)) begin
                scan_idx = '0;
            end else begin
                scan_idx = scan_idx + IDW'(1);
            end
            if (!gnt_found && req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    // Operand slice of the requester being granted this cycle.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = ALU_ADD;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                sel_a  = req_a[i*WIDTH +: WIDTH];
                sel_b  = req_b[i*WIDTH +: WIDTH];
                sel_op = req_sel[i];
            end
        end
    end

    // Accept is blocked while rst is high so the reset view of req_ready is always zero.
    assign accept    = (state == ST_IDLE) && gnt_found && !rst;
    assign alu_done  = (state == ST_WAIT) && alu_ready;
    assign wd_fire   = (state == ST_WAIT) && !alu_ready && (wd_cnt == WDW'(TIMEOUT - 1));
    assign resp_done = (state == ST_RESP) && resp_ready[grant_id];

    // One-hot accept pulse to the winner, only while idle.
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Result strobe routed to the current owner only.
    always_comb begin
        resp_valid = '0;
        if (state == ST_RESP) begin
            resp_valid[grant_id] = 1'b1;
        end
    end

    // ALU start is a single cycle by construction: ISSUE always advances to WAIT.
    assign alu_valid = (state == ST_ISSUE);
    assign busy      = (state != ST_IDLE);

    // Next-state selection for the accept/issue/wait/respond sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept)               state_nxt = ST_ISSUE;
            ST_ISSUE:                           state_nxt = ST_WAIT;
            ST_WAIT:  if (alu_done || wd_fire)  state_nxt = ST_RESP;
            ST_RESP:  if (resp_done)            state_nxt = ST_IDLE;
            default:                            state_nxt = ST_IDLE;
        endcase
    end

    // Control state: FSM, round-robin pointer, owner id and watchdog counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            rr_ptr   <= IDW'(NREQ - 1);
            grant_id <= '0;
            wd_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rr_ptr   <= gnt_idx;
                grant_id <= gnt_idx;
            end
            if (state == ST_WAIT) begin
                wd_cnt <= wd_cnt + WDW'(1);
            end else begin
                wd_cnt <= '0;
            end
        end
    end

    // Datapath: operands latched at accept and held through WAIT; result captured once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= ALU_ADD;
            resp_data <= '0;
        end else begin
            if (accept) begin
                alu_a   <= sel_a;
                alu_b   <= sel_b;
                alu_sel <= sel_op;
            end
            if (alu_done) begin
                resp_data <= alu_result;
            end else if (wd_fire) begin
                resp_data <= HANG_DATA;
            end
        end
    end

    // Sticky hung-ALU flag; only reset clears it, later ops run normally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (wd_fire) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, directed steps, scoreboard of expected results.
// Latency checks assume the modelled ALU answers one cycle after its start pulse.
// The ALU can be told to hang to exercise the watchdog.
module tb_alu_arbiter;
    import cpu_types_pkg::*;

    localparam int W = 32;
    localparam int N = 2;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    alusel_e        req_sel [N];
    logic [N-1:0]   resp_valid;
    logic [N-1:0]   resp_ready;
    logic [W-1:0]   resp_data;
    logic           alu_valid;
    logic           alu_ready;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    alusel_e        alu_sel;
    logic [W-1:0]   alu_result;
    logic [0:0]     grant_id;
    logic           busy;
    logic           err;

    typedef struct {
        int          id;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          total;
    int          bad;
    bit          hang;
    bit          pend;
    logic [31:0] pend_res;

    alu_arbiter #(.WIDTH(W), .NREQ(N), .TIMEOUT(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sel    (req_sel),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .grant_id   (grant_id),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_calc(input logic [31:0] a, input logic [31:0] b, input alusel_e s);
        case (s)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'b0, a < b};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return $signed(a) >>> b[4:0];
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return 32'h0;
        endcase
    endfunction

    // Behavioural ALU: answers one cycle after the start pulse unless told to hang.
    initial begin
        alu_ready  = 1'b0;
        alu_result = '0;
        pend       = 1'b0;
        pend_res   = '0;
        forever begin
            @(posedge clk);
            #1;
            alu_ready = 1'b0;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    alu_ready  = 1'b1;
                    alu_result = pend_res;
                    pend       = 1'b0;
                end
                if (alu_valid && !hang) begin
                    pend     = 1'b1;
                    pend_res = alu_calc(alu_a, alu_b, alu_sel);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not complete");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req_ready"},  32'(req_ready),  32'd0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_alu_valid"},  32'(alu_valid),  32'd0);
        chk({tag, "_busy"},       32'(busy),       32'd0);
        chk({tag, "_err"},        32'(err),        32'd0);
        chk({tag, "_grant_id"},   32'(grant_id),   32'd0);
        chk({tag, "_resp_data"},  resp_data,       32'd0);
        chk({tag, "_alu_a"},      alu_a,           32'd0);
        chk({tag, "_alu_b"},      alu_b,           32'd0);
        chk({tag, "_alu_sel"},    32'(alu_sel),    32'(ALU_ADD));
    endtask

    // Wait for a result, compare against the scoreboard head, then release it.
    task automatic collect(input string tag);
        exp_t        x;
        int          n;
        logic [1:0]  oh;
        n = 0;
        while (resp_valid == '0 && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_resp_seen"}, 32'(|resp_valid), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
        end else begin
            x  = sb.pop_front();
            oh = 2'b01 << x.id;
            chk({tag, "_resp_owner"}, 32'(resp_valid), 32'(oh));
            chk({tag, "_resp_data"},  resp_data,       x.data);
        end
        resp_ready = '1;
        step();
        resp_ready = '0;
        chk({tag, "_resp_drop"}, 32'(resp_valid), 32'd0);
    endtask

    // Single op from one requester with exact cycle-by-cycle timing checks.
    task automatic op_timed(input int id, input logic [31:0] a, input logic [31:0] b,
                            input alusel_e s, input logic [31:0] e, input string tag);
        logic [1:0] oh;
        oh = 2'b01 << id;
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_sel[id]      = s;
        req_valid[id]    = 1'b1;
        #1;
        chk({tag, "_T_req_ready"}, 32'(req_ready), 32'(oh));
        sb.push_back(exp_t'{id, e});
        step();
        req_valid[id] = 1'b0;
        chk({tag, "_T1_alu_valid"}, 32'(alu_valid), 32'd1);
        chk({tag, "_T1_grant_id"},  32'(grant_id),  32'(id));
        chk({tag, "_T1_req_ready"}, 32'(req_ready), 32'd0);
        step();
        chk({tag, "_T2_alu_valid"},  32'(alu_valid),  32'd0);
        chk({tag, "_T2_resp_valid"}, 32'(resp_valid), 32'd0);
        step();
        chk({tag, "_T3_resp_valid"}, 32'(resp_valid), 32'(oh));
        collect(tag);
    endtask

    initial begin
        int          n;
        int          eid;
        logic [31:0] held;

        total      = 0;
        bad        = 0;
        hang       = 1'b0;
        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_sel[0] = ALU_ADD;
        req_sel[1] = ALU_ADD;
        resp_ready = '0;

        // Reset values
        step();
        check_reset("rst0");
        rst = 1'b0;
        step();

        // Basic add on requester 0 with nominal latency
        op_timed(0, 32'd5, 32'd3, ALU_ADD, 32'd8, "add0");

        // Requester 1: sub, signed and unsigned compare
        op_timed(1, 32'd3, 32'd5, ALU_SUB, 32'hFFFF_FFFE, "sub1");
        op_timed(1, 32'd3, 32'd5, ALU_SLT, 32'd1, "slt1");
        op_timed(1, 32'hFFFF_FFFF, 32'd1, ALU_SLTU, 32'd0, "sltu1");

        // Both requesters held high: grants alternate starting at 0
        req_a[0*W +: W] = 32'd10;  req_b[0*W +: W] = 32'd1; req_sel[0] = ALU_ADD;
        req_a[1*W +: W] = 32'd100; req_b[1*W +: W] = 32'd7; req_sel[1] = ALU_SUB;
        req_valid = 2'b11;
        #1;
        for (int k = 0; k < 6; k++) begin
            eid = k % 2;
            n   = 0;
            while (req_ready == '0 && n < 10) begin
                step();
                n++;
            end
            chk("rr_grant", 32'(req_ready), 32'(2'b01 << eid));
            sb.push_back(exp_t'{eid, (eid == 0) ? 32'd11 : 32'd93});
            step();
            chk("rr_grant_id",  32'(grant_id),  32'(eid));
            chk("rr_alu_pulse", 32'(alu_valid), 32'd1);
            step();
            chk("rr_alu_drop",  32'(alu_valid), 32'd0);
            n = 0;
            while (resp_valid == '0 && n < 10) begin
                step();
                n++;
            end
            chk("rr_no_accept_in_resp", 32'(req_ready), 32'd0);
            collect("rr");
        end
        req_valid = '0;
        step();

        // Result held while owner stalls; other requester's ready and valid ignored
        req_a[0*W +: W] = 32'd20;
        req_b[0*W +: W] = 32'd22;
        req_sel[0]      = ALU_ADD;
        req_valid[0]    = 1'b1;
        #1;
        chk("hold_accept", 32'(req_ready), 32'(2'b01));
        sb.push_back(exp_t'{0, 32'd42});
        step();
        req_valid  = 2'b10;
        resp_ready = 2'b10;
        step();
        step();
        held = resp_data;
        chk("hold_first_data", held, 32'd42);
        for (int k = 0; k < 5; k++) begin
            chk("hold_resp_valid", 32'(resp_valid), 32'(2'b01));
            chk("hold_resp_data",  resp_data,       32'd42);
            chk("hold_req_ready",  32'(req_ready),  32'd0);
            step();
        end
        req_valid  = '0;
        resp_ready = '0;
        collect("hold");

        // Hung ALU: watchdog fires after 15 WAIT cycles
        hang            = 1'b1;
        req_a[0*W +: W] = 32'd1;
        req_b[0*W +: W] = 32'd2;
        req_sel[0]      = ALU_ADD;
        req_valid[0]    = 1'b1;
        #1;
        chk("wd_accept", 32'(req_ready), 32'(2'b01));
        sb.push_back(exp_t'{0, 32'hDEAD_BEEF});
        step();
        req_valid = '0;
        chk("wd_alu_valid", 32'(alu_valid), 32'd1);
        chk("wd_err_before", 32'(err), 32'd0);
        n = 0;
        while (resp_valid == '0 && n < 40) begin
            step();
            n++;
            if (resp_valid == '0) chk("wd_err_early", 32'(err), 32'd0);
        end
        chk("wd_cycles", 32'(n), 32'd16);
        chk("wd_err_set", 32'(err), 32'd1);
        collect("wd");
        hang = 1'b0;
        op_timed(1, 32'd7, 32'd2, ALU_AND, 32'd2, "after_wd");
        chk("wd_err_sticky", 32'(err), 32'd1);

        // Reset in the middle of WAIT drops the op and restores reset outputs at once
        hang            = 1'b1;
        req_a[0*W +: W] = 32'd9;
        req_b[0*W +: W] = 32'd9;
        req_valid[0]    = 1'b1;
        #1;
        chk("mid_accept", 32'(req_ready), 32'(2'b01));
        step();
        req_valid = '0;
        step();
        step();
        chk("mid_busy_wait", 32'(busy), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check_reset("rst_async");
        step();
        check_reset("rst_held");
        rst  = 1'b0;
        hang = 1'b0;
        step();
        op_timed(0, 32'd40, 32'd2, ALU_SRL, 32'd10, "post_rst");
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
